// File: rtl/icosoc_mod_eventplay.sv
// Timestamped GPIO event player: bus-loaded {timestamp, value} FIFO replayed against a free-running counter.
// Optional build macro EVENTPLAY_IRQ_EN adds the irq output and the THRESH register at 0x14.
module icosoc_mod_eventplay #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 48,
    parameter int IO_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ctrl_wr,
    input  logic            ctrl_rd,
    input  logic [15:0]     ctrl_addr,
    input  logic [31:0]     ctrl_wdat,
    output logic [31:0]     ctrl_rdat,
    output logic            ctrl_done,
    output logic [IO_W-1:0] io_out
`ifdef EVENTPLAY_IRQ_EN
    ,
    output logic            irq
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int HW = TS_W - 32;

    localparam logic [15:0] ADDR_CTRL   = 16'h0004;
    localparam logic [15:0] ADDR_COUNT  = 16'h0008;
    localparam logic [15:0] ADDR_PUSH   = 16'h000C;
    localparam logic [15:0] ADDR_FLUSH  = 16'h0010;
`ifdef EVENTPLAY_IRQ_EN
    localparam logic [15:0] ADDR_THRESH = 16'h0014;
`endif

    logic [TS_W-1:0] counter_q, counter_d;
    logic            run_q, run_d;
    logic            late_q, late_d;
    logic            ovf_q, ovf_d;
    logic            t8_q, t8_d;
    logic            tc_q, tc_d;
    logic [31:0]     snap_q, snap_d;
    logic [IO_W-1:0] pend_val_q, pend_val_d;
    logic [HW-1:0]   pend_hi_q, pend_hi_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [IO_W-1:0] io_out_q, io_out_d;
    logic [31:0]     rdat_q, rdat_d;
    logic            done_q, done_d;
`ifdef EVENTPLAY_IRQ_EN
    logic [PW-1:0]   thresh_q, thresh_d;
    logic            irq_q, irq_d;
`endif

    logic [TS_W-1:0] fifo_ts_q  [DEPTH];
    logic [IO_W-1:0] fifo_val_q [DEPTH];

    logic [PW-1:0]   fill;
    logic            empty;
    logic            full;
    logic [TS_W-1:0] head_ts;
    logic [IO_W-1:0] head_val;
    logic            acc;
    logic            is_rd;
    logic            is_wr;
    logic            flush;
    logic            fire;
    logic            push_en;
    logic [4:0]      status;

    assign fill     = wptr_q - rptr_q;
    assign empty    = (fill == '0);
    assign full     = (fill == PW'(DEPTH));
    assign head_ts  = fifo_ts_q[rptr_q[AW-1:0]];
    assign head_val = fifo_val_q[rptr_q[AW-1:0]];
    assign acc      = (ctrl_wr || ctrl_rd) && !done_q;
    assign is_rd    = acc && ctrl_rd;
    assign is_wr    = acc && !ctrl_rd;
    assign flush    = is_wr && (ctrl_addr == ADDR_FLUSH);
    // A flush in the same cycle suppresses playback so io_out stays untouched by the flush.
    assign fire     = run_q && !empty && (counter_q >= head_ts) && !flush;
    assign status   = {ovf_q, late_q, full, empty, run_q};

    always_comb begin
        counter_d  = run_q ? counter_q + TS_W'(1) : counter_q;
        run_d      = run_q;
        late_d     = late_q;
        ovf_d      = ovf_q;
        t8_d       = t8_q;
        tc_d       = tc_q;
        snap_d     = snap_q;
        pend_val_d = pend_val_q;
        pend_hi_d  = pend_hi_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        io_out_d   = io_out_q;
        rdat_d     = '0;
        done_d     = acc;
        push_en    = 1'b0;
`ifdef EVENTPLAY_IRQ_EN
        thresh_d   = thresh_q;
        irq_d      = run_q && (fill <= thresh_q);
`endif

        if (fire) begin
            rptr_d   = rptr_q + PW'(1);
            io_out_d = head_val;
            if (counter_q > head_ts) late_d = 1'b1;
        end

        if (is_rd) begin
            case (ctrl_addr)
                ADDR_CTRL: rdat_d = {27'b0, status};
                ADDR_COUNT: begin
                    if (!t8_q) begin
                        rdat_d = 32'(counter_q[TS_W-1:32]);
                        snap_d = counter_q[31:0];
                    end else begin
                        rdat_d = snap_q;
                    end
                    t8_d = !t8_q;
                end
                ADDR_PUSH: rdat_d = 32'(DEPTH) - 32'(fill);
`ifdef EVENTPLAY_IRQ_EN
                ADDR_THRESH: rdat_d = 32'(thresh_q);
`endif
                default: rdat_d = '0;
            endcase
        end

        if (is_wr) begin
            case (ctrl_addr)
                ADDR_CTRL: begin
                    run_d = ctrl_wdat[0];
                    if (ctrl_wdat[3]) late_d = 1'b0;
                    if (ctrl_wdat[4]) ovf_d = 1'b0;
                end
                ADDR_COUNT: begin
                    // A bus load replaces this cycle's increment.
                    if (!t8_q) counter_d = {ctrl_wdat[HW-1:0], counter_q[31:0]};
                    else       counter_d = {counter_q[TS_W-1:32], ctrl_wdat};
                    t8_d = !t8_q;
                end
                ADDR_PUSH: begin
                    if (!tc_q) begin
                        pend_val_d = ctrl_wdat[16 +: IO_W];
                        pend_hi_d  = ctrl_wdat[HW-1:0];
                        tc_d       = 1'b1;
                    end else begin
                        // A simultaneous pop frees the head slot, so a full FIFO still accepts.
                        if (!full || fire) begin
                            push_en = 1'b1;
                            wptr_d  = wptr_q + PW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                        tc_d = 1'b0;
                    end
                end
                ADDR_FLUSH: begin
                    wptr_d = '0;
                    rptr_d = '0;
                    t8_d   = 1'b0;
                    tc_d   = 1'b0;
                end
`ifdef EVENTPLAY_IRQ_EN
                ADDR_THRESH: thresh_d = ctrl_wdat[PW-1:0];
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q <= '0;
            run_q     <= 1'b0;
            late_q    <= 1'b0;
            ovf_q     <= 1'b0;
            t8_q      <= 1'b0;
            tc_q      <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            io_out_q  <= '0;
            rdat_q    <= '0;
            done_q    <= 1'b0;
`ifdef EVENTPLAY_IRQ_EN
            thresh_q  <= '0;
            irq_q     <= 1'b0;
`endif
        end else begin
            counter_q <= counter_d;
            run_q     <= run_d;
            late_q    <= late_d;
            ovf_q     <= ovf_d;
            t8_q      <= t8_d;
            tc_q      <= tc_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            io_out_q  <= io_out_d;
            rdat_q    <= rdat_d;
            done_q    <= done_d;
`ifdef EVENTPLAY_IRQ_EN
            thresh_q  <= thresh_d;
            irq_q     <= irq_d;
`endif
        end
    end

    // Data-only holding registers; their contents are meaningless until the matching first access.
    always_ff @(posedge clk) begin
        snap_q     <= snap_d;
        pend_val_q <= pend_val_d;
        pend_hi_q  <= pend_hi_d;
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_ts_q[wptr_q[AW-1:0]]  <= {pend_hi_q, ctrl_wdat};
            fifo_val_q[wptr_q[AW-1:0]] <= pend_val_q;
        end
    end

    assign ctrl_rdat = rdat_q;
    assign ctrl_done = done_q;
    assign io_out    = io_out_q;
`ifdef EVENTPLAY_IRQ_EN
    assign irq       = irq_q;
`endif

endmodule

// File: doc/icosoc_mod_eventplay.md
Name: icosoc_mod_eventplay

Overview:
Timestamped GPIO event player, the transmit-side counterpart of the trigger recorder. Software pushes {timestamp, io_value} events over the icosoc ctrl bus into an internal FIFO. A free-running timestamp counter drives io_out to each value when the counter reaches that event's timestamp. It is used to replay captured traces and to generate stimulus patterns.

Parameters:
DEPTH, 16, number of event FIFO entries; must be a power of 2, minimum 2
TS_W, 48, timestamp counter width in bits; range 33..48
IO_W, 16, driven IO width in bits; maximum 16

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous reset, active-high
ctrl_wr  in  1  bus write request; held high until ctrl_done
ctrl_rd  in  1  bus read request; held high until ctrl_done
ctrl_addr  in  16  byte register address
ctrl_wdat  in  32  write data
ctrl_rdat  out  32  read data; valid while ctrl_done=1
ctrl_done  out  1  one-cycle access acknowledge
io_out  out  IO_W  played IO value, registered

Behaviour:
- Reset (synchronous, active-high): io_out=0, ctrl_rdat=0, ctrl_done=0, counter=0, run=0, FIFO empty, both half-word toggles=0, sticky flags=0.
- Bus handshake: an access is accepted when (ctrl_wr|ctrl_rd) && !ctrl_done.
  - ctrl_done=1 on the next cycle, for exactly one cycle.
  - Request still high while ctrl_done=1 is ignored. Each access has exactly one side effect.
  - ctrl_rd has priority over ctrl_wr if both are high.
  - Unmapped address: write ignored; read returns 0 and is acked normally.
- Register 0x4 CTRL/STATUS:
  - Write: run=wdat[0]; wdat[3]=1 clears late; wdat[4]=1 clears overflow.
  - Read: {27'b0, overflow, late, full, empty, run}.
- Register 0x8 COUNTER (two accesses, toggle t8):
  - First write (t8=0) loads counter[TS_W-1:32]=wdat[TS_W-33:0].
  - Second write loads counter[31:0].
  - First read returns the upper bits zero-extended and snapshots counter[31:0]; second read returns the snapshot.
  - Reads and writes share t8. Each access flips t8.
  - A counter write takes priority over the increment in the same cycle.
- Register 0xC EVENT PUSH (toggle tc):
  - First write latches {io_value=wdat[31:16], ts_hi=wdat[TS_W-33:0]}.
  - Second write appends {ts_hi, wdat[31:0], io_value} to the FIFO.
  - Read returns the free-entry count (0..DEPTH) and does not flip tc.
- Register 0x10 FLUSH: any write empties the FIFO and clears t8 and tc. io_out and counter are unchanged.
- Counter: increments by 1 each cycle while run=1; wraps from 2^TS_W-1 to 0; holds while run=0.
- Playback: while run=1 and the FIFO is non-empty, the head entry fires in the cycle when counter >= head.ts.
  - Next cycle: io_out=head.value[IO_W-1:0]; head popped.
  - If counter > head.ts at fire, late is set (sticky).
  - At most one event pops per cycle. Equal or past timestamps drain one per cycle, each flagged late except an exact match.
  - Comparison is unsigned with no wrap awareness.
- FIFO full: a second-half push while full is dropped, overflow is set, and tc still returns to 0. A push and a pop in the same cycle are both performed, including when full.
- Empty while running: io_out holds its last value and the counter keeps running.
- Reset asserted mid-operation (including mid-handshake or between half-writes) returns all state to reset values next cycle.

Optional Feature:
EVENTPLAY_IRQ_EN
- With the macro defined:
  - Adds output irq (1 bit, reset 0) and register 0x14 THRESH (read/write, low log2(DEPTH)+1 bits, reset 0).
  - irq is registered and equals run && (fill level <= THRESH).
- Without it: no irq port exists, 0x14 is unmapped, and area is minimal.

Test Plan:
- Handshake: write 0x4=0x1, then read 0x4 -> rdat=0x3 (run, empty). ctrl_done is high exactly one cycle per access; a held ctrl_wr causes no second side effect.
- Counter: run=0, write 0x8 with 0x1 then 0x2, read 0x8 twice -> 0x1 then 0x2. Run 10 cycles and stop -> counter = 0x1_00000002 + 10.
- Exact playback: counter=0, push {0x00A5,0x0000,0x00000020} and {0x005A,0x0000,0x00000030}, set run. io_out=0x00A5 the cycle after counter==0x20, then 0x005A the cycle after 0x30; late=0.
- Late burst: counter=0x100, push three events with ts=0x10 and values 0x1, 0x2, 0x3, run -> io_out steps 1,2,3 on consecutive cycles; late=1; writing 0x4=0x9 clears late and keeps run=1.
- Full/overflow: run=0, push DEPTH+1 events -> status full=1, overflow=1, free count read=0. FLUSH -> empty=1, free=DEPTH.
- Reset mid-push: write the first half to 0xC, pulse reset for 1 cycle, write 0x12340000 to 0xC -> treated as a first half (FIFO stays empty); io_out=0.
